// File: rtl/fetch_decode_reg_pkg.sv
// Shared constants and the decode-slot payload for the fetch/decode pipeline register.
package fetch_decode_reg_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned EXC_W = 5;
    localparam int unsigned OP_W  = 6;

    localparam logic [XLEN-1:0]  RESET_PC   = 32'h0000_3000;
    localparam logic [XLEN-1:0]  HANDLER_PC = 32'h0000_4180;
    localparam logic [EXC_W-1:0] EXC_NONE   = 5'd0;
    localparam logic [EXC_W-1:0] EXC_ADEL   = 5'd4;

    localparam logic [OP_W-1:0] OP_SPECIAL = 6'b000000;
    localparam logic [OP_W-1:0] OP_REGIMM  = 6'b000001;
    localparam logic [OP_W-1:0] OP_J       = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL     = 6'b000011;
    localparam logic [OP_W-1:0] OP_BEQ     = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE     = 6'b000101;
    localparam logic [OP_W-1:0] OP_BLEZ    = 6'b000110;
    localparam logic [OP_W-1:0] OP_BGTZ    = 6'b000111;

    localparam logic [OP_W-1:0] FUNCT_JR   = 6'b001000;
    localparam logic [OP_W-1:0] FUNCT_JALR = 6'b001001;

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  instr;
        logic [EXC_W-1:0] exc_code;
        logic             bd;
        logic             valid;
    } d_slot_t;

    // Empty slot parked at a given PC (reset, flush and eret-kill all use this shape).
    function automatic d_slot_t empty_slot(input logic [XLEN-1:0] pc);
        d_slot_t s;
        s          = '0;
        s.pc       = pc;
        s.exc_code = EXC_NONE;
        return s;
    endfunction

endpackage

// File: rtl/fetch_decode_reg_branch_jump_det.sv
// Flags instruction words that are branches or jumps (their successor is a delay slot).
module branch_jump_det
    import fetch_decode_reg_pkg::*;
(
    input  logic [31:0] instr,
    output logic        is_bj
);

    logic [OP_W-1:0] opcode;
    logic [OP_W-1:0] funct;
    logic            unused_fields;

    assign opcode        = instr[31:26];
    assign funct         = instr[5:0];
    assign unused_fields = ^instr[25:6];

    always_comb begin
        is_bj = 1'b0;
        unique case (opcode)
            OP_REGIMM, OP_J, OP_JAL,
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: is_bj = 1'b1;
            OP_SPECIAL: is_bj = (funct == FUNCT_JR) || (funct == FUNCT_JALR);
            default:    is_bj = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_decode_reg.sv
// IF/ID pipeline register with flush, stall, eret kill and delay-slot tracking.
module fetch_decode_reg
    import fetch_decode_reg_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] F_PC,
    input  logic [31:0] F_Instr,
    input  logic        F_PCError,
    input  logic        stall,
    input  logic        req,
    input  logic        D_eret,
    output logic [31:0] D_PC,
    output logic [31:0] D_Instr,
    output logic [4:0]  D_ExcCode,
    output logic        D_BD,
    output logic        D_Valid
);

    d_slot_t slot;
    d_slot_t slot_nxt;
    logic    cur_is_bj;

    // Delay-slot status is decided by the instruction leaving decode, not the one entering.
    branch_jump_det u_bj_det (
        .instr (slot.instr),
        .is_bj (cur_is_bj)
    );

    always_comb begin
        slot_nxt = slot;
        if (req) begin
            slot_nxt = empty_slot(HANDLER_PC);
        end else if (stall) begin
            slot_nxt = slot;
        end else if (D_eret) begin
            slot_nxt = empty_slot(F_PC);
        end else begin
            slot_nxt.pc    = F_PC;
            slot_nxt.valid = 1'b1;
            slot_nxt.bd    = slot.valid && cur_is_bj;
            if (F_PCError) begin
                slot_nxt.instr    = '0;
                slot_nxt.exc_code = EXC_ADEL;
            end else begin
                slot_nxt.instr    = F_Instr;
                slot_nxt.exc_code = EXC_NONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot <= empty_slot(RESET_PC);
        end else begin
            slot <= slot_nxt;
        end
    end

    assign D_PC      = slot.pc;
    assign D_Instr   = slot.instr;
    assign D_ExcCode = slot.exc_code;
    assign D_BD      = slot.bd;
    assign D_Valid   = slot.valid;

endmodule

// File: tb/tb_fetch_decode_reg.sv
// Directed plus randomized checks of fetch_decode_reg against a behavioural slot model.
module tb_fetch_decode_reg;

    logic        clk;
    logic        reset;
    logic [31:0] F_PC;
    logic [31:0] F_Instr;
    logic        F_PCError;
    logic        stall;
    logic        req;
    logic        D_eret;
    logic [31:0] D_PC;
    logic [31:0] D_Instr;
    logic [4:0]  D_ExcCode;
    logic        D_BD;
    logic        D_Valid;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_pc, m_instr;
    logic [4:0]  m_exc;
    logic        m_bd, m_valid;

    fetch_decode_reg dut (
        .clk       (clk),
        .reset     (reset),
        .F_PC      (F_PC),
        .F_Instr   (F_Instr),
        .F_PCError (F_PCError),
        .stall     (stall),
        .req       (req),
        .D_eret    (D_eret),
        .D_PC      (D_PC),
        .D_Instr   (D_Instr),
        .D_ExcCode (D_ExcCode),
        .D_BD      (D_BD),
        .D_Valid   (D_Valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Opcodes 1..7 are all branches/jumps; opcode 0 only with funct 8 (jr) or 9 (jalr).
    function automatic bit is_branch(input logic [31:0] w);
        int op;
        int fn;
        op = int'(w[31:26]);
        fn = int'(w[5:0]);
        return (op >= 1 && op <= 7) || (op == 0 && (fn == 8 || fn == 9));
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic q, input logic s, input logic e,
                              input logic err, input logic [31:0] pc, input logic [31:0] ins);
        bit next_bd;
        if (r) begin
            m_pc = 32'h3000; m_instr = 0; m_exc = 0; m_bd = 0; m_valid = 0;
        end else if (q) begin
            m_pc = 32'h4180; m_instr = 0; m_exc = 0; m_bd = 0; m_valid = 0;
        end else if (s) begin
            // hold everything
        end else if (e) begin
            m_pc = pc; m_instr = 0; m_exc = 0; m_bd = 0; m_valid = 0;
        end else begin
            next_bd = m_valid && is_branch(m_instr);
            m_bd    = next_bd;
            m_pc    = pc;
            m_valid = 1'b1;
            m_instr = err ? 32'h0 : ins;
            m_exc   = err ? 5'd4 : 5'd0;
        end
    endtask

    task automatic cycle(input logic r, input logic q, input logic s, input logic e,
                         input logic err, input logic [31:0] pc, input logic [31:0] ins);
        @(negedge clk);
        reset = r; req = q; stall = s; D_eret = e;
        F_PCError = err; F_PC = pc; F_Instr = ins;
        model_edge(r, q, s, e, err, pc, ins);
        @(posedge clk);
        #1;
        chk("D_PC",      D_PC,             m_pc);
        chk("D_Instr",   D_Instr,          m_instr);
        chk("D_ExcCode", 32'(D_ExcCode),   32'(m_exc));
        chk("D_BD",      32'(D_BD),        32'(m_bd));
        chk("D_Valid",   32'(D_Valid),     32'(m_valid));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 1) == 1) begin
            w[31:26] = 6'($urandom_range(0, 7));
            if (w[31:26] == 6'd0) w[5:0] = 6'($urandom_range(7, 10));
        end
        return w;
    endfunction

    initial begin
        reset = 1'b0; req = 1'b0; stall = 1'b0; D_eret = 1'b0;
        F_PCError = 1'b0; F_PC = '0; F_Instr = '0;
        m_pc = '0; m_instr = '0; m_exc = '0; m_bd = 1'b0; m_valid = 1'b0;

        // Reset state
        cycle(1, 0, 0, 0, 0, 32'h0, 32'h0);
        chk("reset_pc", D_PC, 32'h3000);

        // Normal load: beq followed by its delay slot
        cycle(0, 0, 0, 0, 0, 32'h3000, 32'h1022_0003);
        cycle(0, 0, 0, 0, 0, 32'h3004, 32'h0000_0000);
        chk("delay_slot_bd", 32'(D_BD), 32'd1);
        chk("delay_slot_pc", D_PC, 32'h3004);

        // Stall hold across three edges
        cycle(0, 0, 1, 0, 0, 32'h3008, 32'h1111_1111);
        cycle(0, 0, 1, 1, 0, 32'h300c, 32'h2222_2222);
        cycle(0, 0, 1, 0, 0, 32'h3010, 32'h3333_3333);
        chk("stall_hold_pc", D_PC, 32'h3004);
        chk("stall_hold_bd", 32'(D_BD), 32'd1);

        // Fetch address error
        cycle(0, 0, 0, 0, 1, 32'h3002, 32'hdead_beef);
        chk("adel_code", 32'(D_ExcCode), 32'd4);
        chk("adel_pc", D_PC, 32'h3002);

        // Flush over stall with a jump in decode; next load is not a delay slot
        cycle(0, 0, 0, 0, 0, 32'h3004, 32'h0800_0c00);
        cycle(0, 1, 1, 0, 0, 32'h3008, 32'h0000_0000);
        chk("flush_pc", D_PC, 32'h4180);
        cycle(0, 0, 0, 0, 0, 32'h4180, 32'h0000_0000);
        chk("after_flush_bd", 32'(D_BD), 32'd0);

        // eret kill after a jr; then eret under stall holds
        cycle(0, 0, 0, 0, 0, 32'h4184, 32'h03e0_0008);
        cycle(0, 0, 0, 1, 0, 32'h4184, 32'h1234_5678);
        chk("kill_valid", 32'(D_Valid), 32'd0);
        chk("kill_pc", D_PC, 32'h4184);
        cycle(0, 0, 0, 0, 0, 32'h3000, 32'h1022_0003);
        cycle(0, 0, 1, 1, 0, 32'h3004, 32'h0000_0000);
        chk("eret_stall_valid", 32'(D_Valid), 32'd1);
        cycle(0, 0, 0, 0, 0, 32'h3004, 32'h0000_0000);
        chk("after_hold_bd", 32'(D_BD), 32'd1);

        // Reset mid-stream with stall and req
        cycle(0, 0, 1, 0, 0, 32'h3008, 32'h0000_0000);
        cycle(1, 1, 1, 1, 1, 32'h5555_5555, 32'hffff_ffff);
        chk("mid_reset_pc", D_PC, 32'h3000);
        cycle(0, 0, 0, 0, 0, 32'h3000, 32'h0000_0008);
        chk("post_reset_valid", 32'(D_Valid), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 7) == 0),
                  32'h3000 + (32'($urandom_range(0, 2047)) << 2) + 32'($urandom_range(0, 15) == 0),
                  rand_instr());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
